coin_input_conditioner: RTL and testbench

Front-end stage directly upstream of the coffee controller's Coin_1 / Coin_5 / Coin_return inputs.
- Synchronises and debounces the raw coin-slot switches and the return button.
- Converts each qualified press into one single-cycle pulse and guarantees at most one pulse per cycle.
- Diverts coins inserted while the machine is busy into a reject pulse.

---
 rtl/coin_input_conditioner.sv | 167 ++++++++++++++++
 tb/tb_coin_input_conditioner.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/coin_input_conditioner.sv
// Coin-slot front end: 2-flop sync, per-channel debounce FSM, priority arbiter, busy reject.
// Define COIN_TOTAL_EN to build the saturating credit accumulator on Total.
module coin_input_conditioner #(
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Coin_1_raw,
  input  logic       Coin_5_raw,
  input  logic       Coin_return_raw,
  input  logic       Busy,
  output logic       Coin_1,
  output logic       Coin_5,
  output logic       Coin_return,
  output logic       Coin_reject,
  output logic       Overrun,
  output logic [7:0] Total
);

  typedef enum logic [1:0] {StLow, StRise, StHigh, StFall} deb_state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  // Channel index: 0 = 1-yuan, 1 = 5-yuan, 2 = return.
  logic [2:0] raw;
  logic [2:0] sync1_q;
  logic [2:0] s;

  assign raw = {Coin_return_raw, Coin_5_raw, Coin_1_raw};

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= '0;
      s       <= '0;
    end else begin
      sync1_q <= raw;
      s       <= sync1_q;
    end
  end

  deb_state_e       state_q [3];
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_inc [3];
  logic [2:0]       event_q;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_inc[i] = cnt_q[i] + CntOne;
    end
  end

  // The event is raised on the edge that enters HIGH, so it lands in the arbiter next cycle.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= StLow;
        cnt_q[i]   <= '0;
      end
      event_q <= '0;
    end else begin
      event_q <= '0;
      for (int i = 0; i < 3; i++) begin
        case (state_q[i])
          StLow: begin
            if (s[i]) begin
              state_q[i] <= StRise;
              cnt_q[i]   <= '0;
            end
          end
          StRise: begin
            if (!s[i]) begin
              state_q[i] <= StLow;
              cnt_q[i]   <= '0;
            end else if (cnt_inc[i] == CntLast) begin
              state_q[i] <= StHigh;
              cnt_q[i]   <= '0;
              event_q[i] <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_inc[i];
            end
          end
          StHigh: begin
            if (!s[i]) begin
              state_q[i] <= StFall;
              cnt_q[i]   <= '0;
            end
          end
          StFall: begin
            if (s[i]) begin
              state_q[i] <= StHigh;
              cnt_q[i]   <= '0;
            end else if (cnt_inc[i] == CntLast) begin
              state_q[i] <= StLow;
              cnt_q[i]   <= '0;
            end else begin
              cnt_q[i] <= cnt_inc[i];
            end
          end
          default: begin
            state_q[i] <= StLow;
            cnt_q[i]   <= '0;
          end
        endcase
      end
    end
  end

  logic [2:0] pend_q;
  logic [2:0] pend_d;
  logic [2:0] eff;
  logic [2:0] serve;
  logic       overrun_d;

  // A fresh event competes in the same cycle it arrives; only unserved leftovers wait.
  always_comb begin
    eff      = pend_q | event_q;
    serve    = '0;
    serve[2] = eff[2];
    serve[1] = eff[1] & ~eff[2];
    serve[0] = eff[0] & ~eff[1] & ~eff[2];
    for (int i = 0; i < 3; i++) begin
      pend_d[i] = serve[i] ? (pend_q[i] & event_q[i]) : eff[i];
    end
    overrun_d = |(pend_q & event_q & ~serve);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_q      <= '0;
      Coin_1      <= 1'b0;
      Coin_5      <= 1'b0;
      Coin_return <= 1'b0;
      Coin_reject <= 1'b0;
      Overrun     <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      Coin_1      <= serve[0] & ~Busy;
      Coin_5      <= serve[1] & ~Busy;
      Coin_return <= serve[2];
      Coin_reject <= (serve[0] | serve[1]) & Busy;
      Overrun     <= overrun_d;
    end
  end

`ifdef COIN_TOTAL_EN
  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, Total} + (Coin_5 ? 9'd5 : (Coin_1 ? 9'd1 : 9'd0));
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Total <= 8'd0;
    end else if (Coin_return) begin
      Total <= 8'd0;
    end else if (Coin_1 || Coin_5) begin
      Total <= sum[8] ? 8'hff : sum[7:0];
    end
  end
`else
  assign Total = 8'd0;
`endif

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Directed bench for coin_input_conditioner with DEB_CYCLES=4: per-cycle vector table
// plus a hand-written reset-during-debounce sequence.
module tb_coin_input_conditioner;

`ifdef COIN_TOTAL_EN
  localparam bit TotEn = 1'b1;
`else
  localparam bit TotEn = 1'b0;
`endif

  // Expected pulse vector bits: {Overrun, Coin_reject, Coin_return, Coin_5, Coin_1}.
  localparam logic [4:0] PC1  = 5'b00001;
  localparam logic [4:0] PC5  = 5'b00010;
  localparam logic [4:0] PRET = 5'b00100;
  localparam logic [4:0] PREJ = 5'b01000;

  logic       clk;
  logic       rst_n;
  logic       c1_raw, c5_raw, cr_raw, busy;
  logic       coin_1, coin_5, coin_return, coin_reject, overrun;
  logic [7:0] total;

  coin_input_conditioner #(
    .DEB_CYCLES(4),
    .CNT_W     (4)
  ) dut (
    .Clock          (clk),
    .Reset_n        (rst_n),
    .Coin_1_raw     (c1_raw),
    .Coin_5_raw     (c5_raw),
    .Coin_return_raw(cr_raw),
    .Busy           (busy),
    .Coin_1         (coin_1),
    .Coin_5         (coin_5),
    .Coin_return    (coin_return),
    .Coin_reject    (coin_reject),
    .Overrun        (overrun),
    .Total          (total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] raw;   // {return, 5, 1}
    logic       busy;
    int         reps;
    logic [4:0] exp;
    logic [7:0] tot;
  } vec_t;

  vec_t vecs[$];
  int   model_tot;
  int   n_cmp;
  int   n_fail;

  function automatic logic [4:0] pulses();
    return {overrun, coin_reject, coin_return, coin_5, coin_1};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h want %0h", name, idx, got, want);
    end
  endtask

  // Row's Total is the credit before its own pulse; the pulse updates the model afterwards.
  task automatic push(input logic [2:0] raw, input logic b, input int reps, input logic [4:0] e);
    vec_t v;
    v.raw  = raw;
    v.busy = b;
    v.reps = reps;
    v.exp  = e;
    v.tot  = TotEn ? 8'(model_tot) : 8'd0;
    vecs.push_back(v);
    if (e == PC1) model_tot = (model_tot + 1 > 255) ? 255 : model_tot + 1;
    else if (e == PC5) model_tot = (model_tot + 5 > 255) ? 255 : model_tot + 5;
    else if (e == PRET) model_tot = 0;
  endtask

  task automatic press(input int ch, input logic b);
    logic [2:0] r;
    logic [4:0] p;
    r = 3'b001 << ch;
    if (ch == 2) p = PRET;
    else if (b) p = PREJ;
    else p = (ch == 1) ? PC5 : PC1;
    push(r, b, 6, 5'd0);
    push(r, b, 1, p);
    push(r, b, 5, 5'd0);
    push(3'b000, b, 12, 5'd0);
  endtask

  task automatic multi(input logic [2:0] r);
    push(r, 1'b0, 6, 5'd0);
    if (r[2]) push(r, 1'b0, 1, PRET);
    if (r[1]) push(r, 1'b0, 1, PC5);
    if (r[0]) push(r, 1'b0, 1, PC1);
    push(r, 1'b0, 4, 5'd0);
    push(3'b000, 1'b0, 12, 5'd0);
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    model_tot = 0;
    rst_n     = 1'b1;
    {c1_raw, c5_raw, cr_raw, busy} = '0;

    // Vector table.
    press(0, 1'b0);                      // single 1-yuan, held then released
    push(3'b010, 1'b0, 3, 5'd0);         // 3-cycle glitch on 5-yuan: no pulse
    push(3'b000, 1'b0, 10, 5'd0);
    multi(3'b011);                       // 5 then 1 on the next cycle
    press(1, 1'b1);                      // busy: reject instead of Coin_5
    press(2, 1'b1);                      // return ignores busy
    press(0, 1'b0);
    press(1, 1'b0);
    press(1, 1'b0);                      // credit 11
    press(2, 1'b0);                      // credit 0
    multi(3'b111);                       // return, 5, 1 over three cycles
    press(2, 1'b0);
    for (int i = 0; i < 53; i++) press(1, 1'b0);  // saturates at 255

    #2 rst_n = 1'b0;
    #1;
    check("reset_pulses", 0, 32'(pulses()), 32'd0);
    check("reset_total", 0, 32'(total), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      for (int r = 0; r < vecs[k].reps; r++) begin
        {cr_raw, c5_raw, c1_raw} = vecs[k].raw;
        busy = vecs[k].busy;
        @(posedge clk);
        #1;
        check("pulses", k, 32'(pulses()), 32'(vecs[k].exp));
        check("total", k, 32'(total), 32'(vecs[k].tot));
      end
    end

    // Reset while 1-yuan is in RISE with cnt=2 and a Coin_5 pulse is on the output.
    busy   = 1'b0;
    c5_raw = 1'b1;
    repeat (2) @(posedge clk);
    #1 c1_raw = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_reset_c5", 0, 32'(pulses()), 32'(PC5));
    #1 rst_n = 1'b0;
    c5_raw = 1'b0;
    #1;
    check("mid_reset_pulses", 0, 32'(pulses()), 32'd0);
    check("mid_reset_total", 0, 32'(total), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      check("post_reset_pulses", e, 32'(pulses()), (e == 7) ? 32'(PC1) : 32'd0);
      check("post_reset_total", e, 32'(total), (TotEn && e >= 8) ? 32'd1 : 32'd0);
    end
    c1_raw = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("idle_pulses", 0, 32'(pulses()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
